// File: rtl/br_stack_pkg.sv
// Shared definitions for the branch checkpoint stack: resolution states,
// default sizing and the per-checkpoint record.
package sys_defs;

    localparam int BR_NUM_DEF    = 4;
    localparam int FL_IDX_W_DEF  = 5;
    localparam int ROB_IDX_W_DEF = 5;
    localparam int BR_STATE_W    = 2;

    typedef enum logic [BR_STATE_W-1:0] {
        BR_NONE       = 2'b00,
        BR_PR_CORRECT = 2'b01,
        BR_PR_WRONG   = 2'b10
    } br_state_e;

    // dep_mask holds the tags of branches that were in flight (older) when
    // this branch was dispatched.
    typedef struct packed {
        logic                     vld;
        logic [FL_IDX_W_DEF-1:0]  fl_head;
        logic [ROB_IDX_W_DEF-1:0] rob_tail;
        logic [BR_NUM_DEF-1:0]    dep_mask;
    } br_entry_t;

endpackage

// File: rtl/br_stack_alloc_pe.sv
// Lowest-index free-slot picker: one-hot of the first entry with vld=0,
// plus a flag when every entry is taken.
module br_alloc_pe #(
    parameter int N = 4
) (
    input  logic [N-1:0] vld_i,
    output logic [N-1:0] free_oh_o,
    output logic         none_o
);

    logic [N-1:0] w_free;

    assign w_free    = ~vld_i;
    // Two's-complement trick isolates the lowest set bit of the free vector.
    assign free_oh_o = w_free & (~w_free + N'(1));
    assign none_o    = ~|w_free;

endmodule

// File: rtl/br_stack.sv
// Branch checkpoint stack: allocates one-hot branch tags with free-list/ROB
// snapshots and produces recovery state on branch resolution.
module br_stack
    import sys_defs::*;
#(
    parameter int BR_NUM    = BR_NUM_DEF,
    parameter int FL_IDX_W  = FL_IDX_W_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_dispatch_en_i,
    input  logic [FL_IDX_W-1:0]   fl_head_i,
    input  logic [ROB_IDX_W-1:0]  rob_tail_i,
    input  logic                  br_rs_en_i,
    input  logic [BR_NUM-1:0]     br_rs_tag_i,
    input  logic                  br_rs_wrong_i,
    output logic [BR_NUM-1:0]     br_tag_o,
    output logic [BR_NUM-1:0]     br_mask_o,
    output logic                  br_full_o,
    output logic [BR_STATE_W-1:0] br_state_o,
    output logic [FL_IDX_W-1:0]   rc_head_o,
    output logic [ROB_IDX_W-1:0]  rc_rob_tail_o,
    output logic [BR_NUM-1:0]     br_squash_mask_o
);

    br_entry_t             r_ent [BR_NUM];
    logic [BR_NUM-1:0]     w_vld;
    logic [BR_NUM-1:0]     w_free_oh;
    logic                  w_none;
    logic                  w_rs_hit;
    logic                  w_correct;
    logic                  w_wrong;
    logic                  w_alloc;
    logic [BR_NUM-1:0]     w_new_dep;
    logic [BR_NUM-1:0]     w_younger;
    logic [FL_IDX_W-1:0]   w_sel_head;
    logic [ROB_IDX_W-1:0]  w_sel_rob;
    br_state_e             w_state;

    br_alloc_pe #(.N(BR_NUM)) u_alloc_pe (
        .vld_i     (w_vld),
        .free_oh_o (w_free_oh),
        .none_o    (w_none)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // holding its old value, which would infer a latch.
    always_comb begin
        w_vld      = '0;
        w_younger  = '0;
        w_sel_head = '0;
        w_sel_rob  = '0;
        for (int j = 0; j < BR_NUM; j++) begin
            w_vld[j]     = r_ent[j].vld;
            w_younger[j] = r_ent[j].vld && |(r_ent[j].dep_mask & br_rs_tag_i);
            if (br_rs_tag_i[j]) begin
                w_sel_head = w_sel_head | r_ent[j].fl_head;
                w_sel_rob  = w_sel_rob  | r_ent[j].rob_tail;
            end
        end
    end

    assign w_rs_hit  = br_rs_en_i && |(br_rs_tag_i & w_vld);
    assign w_correct = w_rs_hit && !br_rs_wrong_i;
    assign w_wrong   = w_rs_hit &&  br_rs_wrong_i;
    // A mispredict redirects the front end, so a same-cycle dispatch is dropped.
    assign w_alloc   = br_dispatch_en_i && !w_none && !w_wrong;
    assign w_new_dep = w_vld & ~(w_correct ? br_rs_tag_i : '0);

    always_comb begin
        w_state = BR_NONE;
        if (w_rs_hit) w_state = br_rs_wrong_i ? BR_PR_WRONG : BR_PR_CORRECT;
    end

    assign br_state_o       = w_state;
    assign br_mask_o        = w_vld;
    assign br_full_o        = &w_vld;
    assign br_tag_o         = w_alloc ? w_free_oh : '0;
    assign rc_head_o        = w_wrong ? w_sel_head : '0;
    assign rc_rob_tail_o    = w_wrong ? w_sel_rob  : '0;
    assign br_squash_mask_o = w_wrong ? (br_rs_tag_i | w_younger) : '0;

    // NOTE: the checkpoint array is small flop storage, so it is cleared
    // entirely on reset rather than only clearing the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < BR_NUM; j++) r_ent[j] <= '0;
        end else begin
            for (int j = 0; j < BR_NUM; j++) begin
                if (w_correct) begin
                    r_ent[j].dep_mask <= r_ent[j].dep_mask & ~br_rs_tag_i;
                    if (br_rs_tag_i[j]) r_ent[j].vld <= 1'b0;
                end
                if (w_wrong && br_squash_mask_o[j]) r_ent[j].vld <= 1'b0;
                if (w_alloc && w_free_oh[j]) begin
                    r_ent[j] <= '{vld: 1'b1, fl_head: fl_head_i,
                                  rob_tail: rob_tail_i, dep_mask: w_new_dep};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && br_rs_en_i) assert ($onehot0(br_rs_tag_i));
    end

endmodule

// File: tb/tb_br_stack.sv
// Directed plus random stimulus for br_stack against an age-ordered reference
// model: younger branches are those dispatched later and still in flight.
module tb_br_stack;
    import sys_defs::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       br_dispatch_en_i = 1'b0;
    logic [4:0] fl_head_i = '0;
    logic [4:0] rob_tail_i = '0;
    logic       br_rs_en_i = 1'b0;
    logic [3:0] br_rs_tag_i = '0;
    logic       br_rs_wrong_i = 1'b0;
    logic [3:0] br_tag_o;
    logic [3:0] br_mask_o;
    logic       br_full_o;
    logic [1:0] br_state_o;
    logic [4:0] rc_head_o;
    logic [4:0] rc_rob_tail_o;
    logic [3:0] br_squash_mask_o;

    int total = 0;
    int bad   = 0;

    // Reference model: per-tag validity, snapshots and dispatch sequence number.
    logic       m_vld [4];
    logic [4:0] m_fl  [4];
    logic [4:0] m_rob [4];
    int         m_seq [4];
    int         seq_ctr = 0;

    always #5 clk = ~clk;

    br_stack dut (
        .clk              (clk),
        .rst              (rst),
        .br_dispatch_en_i (br_dispatch_en_i),
        .fl_head_i        (fl_head_i),
        .rob_tail_i       (rob_tail_i),
        .br_rs_en_i       (br_rs_en_i),
        .br_rs_tag_i      (br_rs_tag_i),
        .br_rs_wrong_i    (br_rs_wrong_i),
        .br_tag_o         (br_tag_o),
        .br_mask_o        (br_mask_o),
        .br_full_o        (br_full_o),
        .br_state_o       (br_state_o),
        .rc_head_o        (rc_head_o),
        .rc_rob_tail_o    (rc_rob_tail_o),
        .br_squash_mask_o (br_squash_mask_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 1'b0;
            m_fl[i]  = '0;
            m_rob[i] = '0;
            m_seq[i] = 0;
        end
    endtask

    task automatic set_idle();
        br_dispatch_en_i = 1'b0;
        fl_head_i        = '0;
        rob_tail_i       = '0;
        br_rs_en_i       = 1'b0;
        br_rs_tag_i      = '0;
        br_rs_wrong_i    = 1'b0;
    endtask

    // Reset with busy inputs (rst must win), then check every output idles.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        br_dispatch_en_i = 1'b1;
        fl_head_i = 5'd17;
        rob_tail_i = 5'd9;
        br_rs_en_i = 1'b1;
        br_rs_tag_i = 4'b0001;
        br_rs_wrong_i = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        check("rst_mask",   br_mask_o,        4'b0000);
        check("rst_full",   br_full_o,        1'b0);
        check("rst_tag",    br_tag_o,         4'b0000);
        check("rst_state",  br_state_o,       BR_NONE);
        check("rst_head",   rc_head_o,        5'd0);
        check("rst_rob",    rc_rob_tail_o,    5'd0);
        check("rst_squash", br_squash_mask_o, 4'b0000);
    endtask

    // One cycle: drive inputs, compare combinational outputs against the model,
    // clock the edge, then advance the model.
    task automatic step(input logic disp, input logic [4:0] fl, input logic [4:0] rob,
                        input logic rs_en, input logic [3:0] tag, input logic wrong);
        int         idx;
        int         a;
        logic       hit;
        logic       full;
        logic [3:0] e_mask, e_tag, e_sq;
        logic [1:0] e_state;
        logic [4:0] e_head, e_rob;
        @(negedge clk);
        br_dispatch_en_i = disp;
        fl_head_i        = fl;
        rob_tail_i       = rob;
        br_rs_en_i       = rs_en;
        br_rs_tag_i      = tag;
        br_rs_wrong_i    = wrong;
        #1;
        idx = -1;
        for (int i = 0; i < 4; i++) if (tag[i]) idx = i;
        hit  = rs_en && (idx >= 0) && m_vld[idx];
        full = 1'b1;
        e_mask = '0;
        for (int i = 0; i < 4; i++) begin
            e_mask[i] = m_vld[i];
            if (!m_vld[i]) full = 1'b0;
        end
        e_state = !hit ? BR_NONE : (wrong ? BR_PR_WRONG : BR_PR_CORRECT);
        e_head = (hit && wrong) ? m_fl[idx]  : 5'd0;
        e_rob  = (hit && wrong) ? m_rob[idx] : 5'd0;
        e_sq = '0;
        if (hit && wrong)
            for (int i = 0; i < 4; i++)
                if (i == idx || (m_vld[i] && m_seq[i] > m_seq[idx])) e_sq[i] = 1'b1;
        a = -1;
        if (disp && !full && !(hit && wrong))
            for (int i = 3; i >= 0; i--) if (!m_vld[i]) a = i;
        e_tag = (a >= 0) ? 4'(1 << a) : 4'b0000;

        check("mask",   br_mask_o,        e_mask);
        check("full",   br_full_o,        full);
        check("tag",    br_tag_o,         e_tag);
        check("state",  br_state_o,       e_state);
        check("head",   rc_head_o,        e_head);
        check("rob",    rc_rob_tail_o,    e_rob);
        check("squash", br_squash_mask_o, e_sq);

        @(posedge clk);
        if (hit && !wrong) m_vld[idx] = 1'b0;
        if (hit && wrong)
            for (int i = 0; i < 4; i++) if (e_sq[i]) m_vld[i] = 1'b0;
        if (a >= 0) begin
            seq_ctr++;
            m_vld[a] = 1'b1;
            m_fl[a]  = fl;
            m_rob[a] = rob;
            m_seq[a] = seq_ctr;
        end
        #1;
    endtask

    initial begin
        logic [3:0] rtag;
        int         r;
        model_clear();
        set_idle();
        do_reset();

        // Fill all four checkpoints, then dispatch while full.
        step(1, 5'd3,  5'd1, 0, 4'b0000, 0);
        step(1, 5'd7,  5'd2, 0, 4'b0000, 0);
        step(1, 5'd9,  5'd3, 0, 4'b0000, 0);
        step(1, 5'd12, 5'd4, 0, 4'b0000, 0);
        check("p1_full", br_full_o, 1'b1);
        step(1, 5'd31, 5'd31, 0, 4'b0000, 0);
        check("p1_mask_unchanged", br_mask_o, 4'b1111);

        // Mispredict on the second-oldest branch squashes it and all younger.
        step(0, 5'd0, 5'd0, 1, 4'b0010, 1);
        check("p2_mask", br_mask_o, 4'b0001);

        // Correct resolve of the oldest, then mispredict of the next.
        step(1, 5'd10, 5'd5, 0, 4'b0000, 0);
        step(1, 5'd11, 5'd6, 0, 4'b0000, 0);
        step(1, 5'd13, 5'd7, 0, 4'b0000, 0);
        step(0, 5'd0, 5'd0, 1, 4'b0001, 0);
        check("p3_mask", br_mask_o, 4'b1110);
        step(0, 5'd0, 5'd0, 1, 4'b0010, 1);
        check("p3_mask_after_wrong", br_mask_o, 4'b0000);

        // Correct resolve plus dispatch in the same cycle.
        step(1, 5'd1, 5'd1, 0, 4'b0000, 0);
        step(1, 5'd2, 5'd2, 0, 4'b0000, 0);
        step(1, 5'd20, 5'd8, 1, 4'b0001, 0);
        check("p4_mask", br_mask_o, 4'b0110);
        step(0, 5'd0, 5'd0, 1, 4'b0100, 1);
        check("p4_dep_mask", br_mask_o, 4'b0010);
        step(0, 5'd0, 5'd0, 1, 4'b0010, 1);

        // Mispredict plus dispatch: only the squash takes effect.
        step(1, 5'd4, 5'd4, 0, 4'b0000, 0);
        step(1, 5'd5, 5'd5, 0, 4'b0000, 0);
        step(1, 5'd6, 5'd6, 1, 4'b0001, 1);
        check("p5_mask", br_mask_o, 4'b0000);

        // Resolve of an invalid tag, then reset mid-stack.
        step(1, 5'd8, 5'd8, 0, 4'b0000, 0);
        step(0, 5'd0, 5'd0, 1, 4'b0100, 1);
        check("p6_mask", br_mask_o, 4'b0001);
        step(1, 5'd9,  5'd9,  0, 4'b0000, 0);
        step(1, 5'd10, 5'd10, 0, 4'b0000, 0);
        do_reset();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 4);
                rtag = (r == 4) ? 4'b0000 : 4'(1 << r);
                step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                     1'($urandom_range(0, 1)), rtag,
                     1'($urandom_range(0, 9) < 3));
            end
        end

        set_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
